rx_matched_filter: RTL and testbench

Receive-side matched filter for the 4-level PAM link, mirroring the 21-tap symmetric transmit pulse-shaping filter. It accepts one 18-bit sample per `sam_en` strobe and runs a folded symmetric FIR: one pre-adder, one multiplier and one accumulator, time-shared over 11 clock cycles. It emits one filtered sample with a `y_valid` pulse. It sits between the ADC/decimation front end and the timing-recovery/slicer stage.

---
 rtl/rx_filter_pkg.sv | 31 +++
 rtl/rx_matched_filter_sat_round18.sv | 24 ++
 rtl/rx_matched_filter.sv | 151 +++++++++++++++
 tb/tb_rx_matched_filter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_filter_pkg.sv
// rtl/rx_filter_pkg.sv - shared constants, coefficients and state type for the receive matched filter
package rx_filter_pkg;
  localparam int NTAPS  = 21;
  localparam int NUNIQ  = 11;
  localparam int SAMP_W = 18;
  localparam int PROD_W = 37;
  localparam int ACC_W  = 40;
  localparam int FRAC_W = 17;

  // Unique half of the symmetric impulse response, centre tap last
  localparam logic signed [SAMP_W-1:0] COEF [NUNIQ] = '{
    18'sd423, 18'sd1470, 18'sd1598, -18'sd615, -18'sd4766, -18'sd7459,
    -18'sd3713, 18'sd9251, 18'sd28642, 18'sd46363, 18'sd53546
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Coefficient lookup for the running tap index; out-of-range indices read as zero
  function automatic logic signed [SAMP_W-1:0] coef_at(input logic [3:0] k);
    logic signed [SAMP_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUNIQ; i++) begin
      if (k == 4'(i)) c = COEF[i];
    end
    return c;
  endfunction
endpackage

// File: rtl/rx_matched_filter_sat_round18.sv
// rtl/rx_matched_filter_sat_round18.sv - accumulator >>> 17 with saturation to signed 18 bits
module sat_round18
  import rx_filter_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [SAMP_W-1:0] y_o
);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] LO = -ACC_W'(131072);

  logic signed [ACC_W-1:0] shifted;

  // Drop the fractional bits, then clamp to the 1s17 output range
  always_comb begin
    shifted = acc_i >>> FRAC_W;
    if (shifted > HI) begin
      y_o = 18'sh1FFFF;
    end else if (shifted < LO) begin
      y_o = 18'sh20000;
    end else begin
      y_o = shifted[SAMP_W-1:0];
    end
  end
endmodule

// File: rtl/rx_matched_filter.sv
// rtl/rx_matched_filter.sv - folded symmetric 21-tap matched filter, 11-cycle MAC; RX_SLICER_EN adds the symbol slicer
module rx_matched_filter
  import rx_filter_pkg::*;
#(
  parameter int SLICE_THR = 32768
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sam_en,
  input  logic signed [SAMP_W-1:0] x_in,
  output logic signed [SAMP_W-1:0] y,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic [1:0]               sym_out,
  output logic                     sym_valid
);
  state_t state_q, state_d;
  logic [3:0] k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [SAMP_W-1:0] x_q [NTAPS];
  logic signed [SAMP_W-1:0] x_d [NTAPS];
  logic signed [SAMP_W-1:0] y_q, y_d;
  logic y_valid_q, y_valid_d;
  logic overrun_q, overrun_d;

  logic signed [SAMP_W-1:0] tap_a, tap_b, coef_k, y_sat;
  logic signed [SAMP_W:0]   pre_sum;
  logic signed [PROD_W-1:0] product;

  sat_round18 u_sat (
    .acc_i (acc_q),
    .y_o   (y_sat)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: accept only in IDLE, 11 MAC cycles, one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sam_en) state_d = ST_MAC;
      ST_MAC:  if (k_q == 4'(NUNIQ-1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pick the mirrored tap pair for index k, pre-add it and scale by b[k]; centre tap is unpaired
  always_comb begin
    tap_a = '0;
    tap_b = '0;
    for (int i = 0; i < NUNIQ; i++) begin
      if (k_q == 4'(i)) begin
        tap_a = x_q[i];
        tap_b = x_q[NTAPS-1-i];
      end
    end
    if (k_q == 4'(NUNIQ-1)) pre_sum = {tap_a[SAMP_W-1], tap_a};
    else                    pre_sum = {tap_a[SAMP_W-1], tap_a} + {tap_b[SAMP_W-1], tap_b};
    coef_k  = coef_at(k_q);
    product = PROD_W'(pre_sum) * PROD_W'(coef_k);
  end

  // Datapath and outputs per state; strobes outside IDLE are dropped and flagged
  always_comb begin
    x_d       = x_q;
    k_d       = k_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    overrun_d = overrun_q;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (sam_en) begin
          x_d[0] = x_in;
          for (int i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
          acc_d = '0;
          k_d   = '0;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(product);
        k_d   = k_q + 4'd1;
      end
      ST_DONE: begin
        y_d       = y_sat;
        y_valid_d = 1'b1;
      end
      default: ;
    endcase
    if (sam_en && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign overrun = overrun_q;

`ifdef RX_SLICER_EN
  logic [1:0] sym_q, sym_d;

  // Slice the value that y takes at the DONE edge into one of four PAM levels
  always_comb begin
    sym_d = sym_q;
    if (state_q == ST_DONE) begin
      if (y_sat < -SLICE_THR)     sym_d = 2'b00;
      else if (y_sat < 0)         sym_d = 2'b01;
      else if (y_sat < SLICE_THR) sym_d = 2'b10;
      else                        sym_d = 2'b11;
    end
  end

  // Symbol register, updated together with y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sym_q <= 2'b00;
    else       sym_q <= sym_d;
  end

  assign sym_out   = sym_q;
  assign sym_valid = y_valid_q;
`else
  logic [31:0] slice_thr_unused;
  assign slice_thr_unused = SLICE_THR;
  assign sym_out   = 2'b00;
  assign sym_valid = 1'b0;
`endif
endmodule

// File: tb/tb_rx_matched_filter.sv
// tb/tb_rx_matched_filter.sv - self-checking bench for rx_matched_filter
module tb_rx_matched_filter;
`ifdef RX_SLICER_EN
  localparam bit SLICER = 1'b1;
`else
  localparam bit SLICER = 1'b0;
`endif
  localparam int NT = 21;

  logic clk = 1'b0;
  logic reset;
  logic sam_en;
  logic signed [17:0] x_in;
  logic signed [17:0] y;
  logic y_valid, busy, overrun, sym_valid;
  logic [1:0] sym_out;

  int n_cmp = 0;
  int n_bad = 0;

  int bc [11] = '{423, 1470, 1598, -615, -4766, -7459, -3713, 9251, 28642, 46363, 53546};
  longint hist [NT];

  typedef struct {
    logic signed [17:0] x;
    int                 y_exp;
  } vec_t;
  vec_t tbl [22];
  int imp_y [22] = '{-423, -1470, -1598, 615, 4766, 7459, 3713, -9251, -28642, -46363, -53546,
                     -46363, -28642, -9251, 3713, 7459, 4766, 615, -1598, -1470, -423, 0};

  rx_matched_filter dut (
    .clk       (clk),
    .reset     (reset),
    .sam_en    (sam_en),
    .x_in      (x_in),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun),
    .sym_out   (sym_out),
    .sym_valid (sym_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint h_of(input int k);
    return (k <= 10) ? longint'(bc[k]) : longint'(bc[20-k]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NT; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input longint v);
    for (int i = NT-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endfunction

  // Convolution of the last 21 accepted samples with the full impulse response
  function automatic longint model_y();
    longint acc;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += hist[k] * h_of(k);
    acc = acc >>> 17;
    if (acc > 131071)  acc = 131071;
    if (acc < -131072) acc = -131072;
    return acc;
  endfunction

  function automatic logic [1:0] exp_sym(input longint yv);
    if (!SLICER)           return 2'b00;
    if (yv < -32768)       return 2'b00;
    else if (yv < 0)       return 2'b01;
    else if (yv < 32768)   return 2'b10;
    return 2'b11;
  endfunction

  // One strobe, wait for the result, check it, then pad the spacing to 16 clocks
  task automatic run_sample(input logic signed [17:0] v, input string tag, output logic signed [17:0] y_got);
    int cyc;
    longint ye;
    @(negedge clk);
    sam_en = 1'b1;
    x_in   = v;
    model_push(v);
    @(negedge clk);
    sam_en = 1'b0;
    cyc = 1;
    chk({tag, ".busy_hi"}, busy, 1);
    while (!y_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    ye = model_y();
    y_got = y;
    chk({tag, ".latency"}, cyc, 13);
    chk({tag, ".y"}, y, ye);
    chk({tag, ".sym"}, sym_out, exp_sym(ye));
    chk({tag, ".sym_valid"}, sym_valid, SLICER ? 1 : 0);
    chk({tag, ".busy_lo"}, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  // Strobe v1, optionally strobe v2 at a later cycle, and record y_valid pulses over 30 cycles
  task automatic run_window(input logic signed [17:0] v1, input int second_at, input logic signed [17:0] v2,
                            output int pulses, output int first_at, output logic signed [17:0] y_first);
    pulses   = 0;
    first_at = -1;
    y_first  = '0;
    @(negedge clk);
    sam_en = 1'b1;
    x_in   = v1;
    model_push(v1);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (y_valid) begin
        if (pulses == 0) begin
          first_at = c;
          y_first  = y;
        end
        pulses++;
      end
      sam_en = (c == second_at);
      x_in   = v2;
    end
    sam_en = 1'b0;
  endtask

  initial begin
    logic signed [17:0] yg;
    logic signed [17:0] v;
    logic [31:0] r;
    int pulses, first_at;

    reset  = 1'b0;
    sam_en = 1'b0;
    x_in   = '0;
    model_clear();
    for (int i = 0; i < 22; i++) begin
      tbl[i].x     = (i == 0) ? -18'sd131072 : 18'sd0;
      tbl[i].y_exp = imp_y[i];
    end

    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.y", y, 0);
    chk("rst.y_valid", y_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.sym_out", sym_out, 0);
    chk("rst.sym_valid", sym_valid, 0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_sample(tbl[i].x, $sformatf("imp%0d", i), yg);
      chk($sformatf("imp%0d.table", i), yg, tbl[i].y_exp);
    end

    for (int i = 0; i < 21; i++) run_sample(-18'sd131072, $sformatf("dcneg%0d", i), yg);
    chk("dcneg.sat", yg, -131072);
    for (int i = 0; i < 21; i++) run_sample(18'sd131071, $sformatf("dcpos%0d", i), yg);
    chk("dcpos.sat", yg, 131071);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      case (r[31:30])
        2'd0:    v = 18'sd131071;
        2'd1:    v = -18'sd131072;
        default: v = r[17:0];
      endcase
      run_sample(v, $sformatf("rnd%0d", i), yg);
    end

    chk("ovr.pre", overrun, 0);
    run_window(18'sd70000, 5, -18'sd90000, pulses, first_at, yg);
    chk("ovr.pulses", pulses, 1);
    chk("ovr.first_at", first_at, 13);
    chk("ovr.y", yg, model_y());
    chk("ovr.flag", overrun, 1);
    run_sample(18'sd1234, "ovr.after", yg);
    chk("ovr.sticky", overrun, 1);

    @(negedge clk);
    sam_en = 1'b1;
    x_in   = 18'sd100000;
    @(negedge clk);
    sam_en = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmac.y", y, 0);
    chk("rstmac.y_valid", y_valid, 0);
    chk("rstmac.busy", busy, 0);
    chk("rstmac.overrun", overrun, 0);
    chk("rstmac.sym_out", sym_out, 0);
    chk("rstmac.sym_valid", sym_valid, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (y_valid) pulses++;
    end
    chk("rstmac.no_valid", pulses, 0);
    run_sample(-18'sd131072, "rstmac.next", yg);
    chk("rstmac.next_val", yg, -423);

    run_window(18'sd50000, 12, 18'sd77777, pulses, first_at, yg);
    chk("edge12.pulses", pulses, 1);
    chk("edge12.first_at", first_at, 13);
    chk("edge12.y", yg, model_y());
    chk("edge12.overrun", overrun, 1);
    run_sample(-18'sd3000, "edge12.after", yg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
